alu_seq_unit: RTL and testbench
===============================

ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; legal values 8 to 64, power of two.
REQ-002 Parameter ENABLE_MUL, default 1: 1 enables the iterative MUL operation; 0 removes MUL decode.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  operation request present.
REQ-006 in_ready  out  1  unit can accept a request this cycle.
REQ-007 op  in  7  instruction opcode; only bit 5 is used.
REQ-008 ALUop  in  2  main-decoder class: 00 add, 01 subtract, 10 decode funct fields, 11 treated as 00.
REQ-009 funct3  in  3  instruction funct3.
REQ-010 funct7  in  7  instruction funct7.
REQ-011 src_a, src_b  in  WIDTH  operands.
REQ-012 out_valid  out  1  result register holds a valid result.
REQ-013 out_ready  in  1  consumer accepts the result.
REQ-014 result  out  WIDTH  registered result.
REQ-015 zero  out  1  registered flag, set when result equals 0.
REQ-016 ALUcontrol  out  4  registered control code of the accepted operation.
REQ-017 busy  out  1  high while the state is BUSY.

Function
REQ-018 ALUcontrol codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001, MUL 1010.
REQ-019 Decode for ALUop 00 or 11 → ADD; ALUop 01 → SUB.
REQ-020 Decode for ALUop 10, by funct3:
- 000 → SUB if op[5]=1 and funct7[5]=1, otherwise ADD
- 001 → SLL
- 010 → SLT
- 011 → SLTU
- 100 → XOR
- 101 → SRA if funct7[5]=1, otherwise SRL
- 110 → OR
- 111 → AND
REQ-021 When ENABLE_MUL=1, ALUop=10, op[5]=1, funct7=0000001 and funct3=000, the decode is MUL; this rule takes priority over REQ-020.
REQ-022 When ENABLE_MUL=0, the MUL pattern decodes as ADD.
REQ-023 Arithmetic is modulo 2^WIDTH.
REQ-024 SLT compares signed and SLTU compares unsigned; each yields 1 or 0, zero-extended to WIDTH.
REQ-025 Shift amount is src_b[log2(WIDTH)-1:0]; SRA replicates src_a[WIDTH-1].
REQ-026 MUL produces the low WIDTH bits of the unsigned product, computed by shift-add at one bit per cycle.
REQ-027 FSM states: IDLE, BUSY, DONE.
REQ-028 in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-029 A request is accepted when in_valid && in_ready; ALUcontrol and the operands are captured at acceptance.
REQ-030 IDLE with a non-MUL accept: go to DONE; result and zero are valid on the next cycle (latency 1).
REQ-031 IDLE with a MUL accept: go to BUSY, load a counter with WIDTH and clear the accumulator.
REQ-032 BUSY: each cycle, add the multiplicand to the accumulator if the multiplier LSB is 1, shift the multiplicand left, shift the multiplier right, and decrement the counter.
REQ-033 BUSY exits to DONE when the counter reaches 0; out_valid asserts exactly WIDTH+1 cycles after acceptance.
REQ-034 In BUSY, in_valid is ignored.
REQ-035 DONE: result, zero and ALUcontrol hold stable until out_valid && out_ready, then go to IDLE; in_ready rises the following cycle.
REQ-036 out_ready asserted outside DONE has no effect.
REQ-037 in_valid without in_ready loses nothing: the requester holds its inputs until accepted.

Reset
REQ-038 rst asserted at any time, including mid-MUL: state → IDLE; result, zero, ALUcontrol, busy, out_valid and the counter → 0.
REQ-039 After rst deasserts, in_ready=1 on the first clock edge.
REQ-040 No partial MUL result survives reset.

Verification
REQ-041 ALUop=10, op[5]=1, funct3=000, funct7=0100000, a=5, b=7 → one cycle later: out_valid=1, ALUcontrol=0001, result=0xFFFFFFFE, zero=0.
REQ-042 ALUop=10, funct3=101, funct7=0100000, a=0x80000000, b=4 → result=0xF8000000; same inputs with funct7=0 → result=0x08000000.
REQ-043 MUL with a=0x12345, b=0x10 → out_valid exactly 33 cycles after accept, result=0x123450, busy high for 32 cycles; with ENABLE_MUL=0 the same inputs → ADD, result=0x12355.
REQ-044 out_ready held low for 5 cycles in DONE → result stable and in_ready=0 throughout; out_ready=1 → in_ready=1 on the next cycle.
REQ-045 rst pulsed at cycle 10 of a MUL → all outputs 0 immediately, in_ready=1 after release, a new ADD with a=b=0 → zero=1.
REQ-046 Random legal decode sweep at WIDTH=8 and WIDTH=32 against a reference model, covering SLT/SLTU with b=0x80000000, a=1 → SLT=0, SLTU=1.

Source files
------------

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: single-issue ALU with RISC-V style decode, valid/ready
// handshakes on both sides and an iterative shift-add multiplier.
// Non-MUL operations complete in one cycle; MUL retires one multiplier bit
// per cycle and presents its result WIDTH+1 cycles after acceptance.
module alu_seq_unit #(
    parameter int WIDTH      = 32,
    parameter int ENABLE_MUL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       op,
    input  logic [1:0]       ALUop,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [3:0]       ALUcontrol,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    localparam logic [3:0] C_ADD  = 4'd0;
    localparam logic [3:0] C_SUB  = 4'd1;
    localparam logic [3:0] C_AND  = 4'd2;
    localparam logic [3:0] C_OR   = 4'd3;
    localparam logic [3:0] C_XOR  = 4'd4;
    localparam logic [3:0] C_SLT  = 4'd5;
    localparam logic [3:0] C_SLTU = 4'd6;
    localparam logic [3:0] C_SLL  = 4'd7;
    localparam logic [3:0] C_SRL  = 4'd8;
    localparam logic [3:0] C_SRA  = 4'd9;
    localparam logic [3:0] C_MUL  = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [CW-1:0]    count_reg;

    logic [3:0]       dec_ctl;
    logic [WIDTH-1:0] alu_val;
    logic [WIDTH-1:0] step_sum;
    logic [SHW-1:0]   shamt;
    logic             mul_pattern;

    // Only op[5] matters to the decoder; the other opcode bits are don't-care.
    logic unused_op_bits;
    assign unused_op_bits = ^{op[6], op[4:0]};

    assign shamt       = src_b[SHW-1:0];
    assign mul_pattern = (ENABLE_MUL != 0) && op[5] && (funct7 == 7'b0000001)
                         && (funct3 == 3'b000);
    assign step_sum    = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

    // Decode the operation class and funct fields into a control code.
    always_comb begin
        dec_ctl = C_ADD;
        case (ALUop)
            2'b01: dec_ctl = C_SUB;
            2'b10: begin
                if (mul_pattern) begin
                    dec_ctl = C_MUL;
                end else begin
                    case (funct3)
                        3'b000:  dec_ctl = (op[5] && funct7[5]) ? C_SUB : C_ADD;
                        3'b001:  dec_ctl = C_SLL;
                        3'b010:  dec_ctl = C_SLT;
                        3'b011:  dec_ctl = C_SLTU;
                        3'b100:  dec_ctl = C_XOR;
                        3'b101:  dec_ctl = funct7[5] ? C_SRA : C_SRL;
                        3'b110:  dec_ctl = C_OR;
                        default: dec_ctl = C_AND;
                    endcase
                end
            end
            default: dec_ctl = C_ADD;
        endcase
    end

    // Single-cycle datapath for every code except MUL.
    always_comb begin
        alu_val = '0;
        case (dec_ctl)
            C_ADD:   alu_val = src_a + src_b;
            C_SUB:   alu_val = src_a - src_b;
            C_AND:   alu_val = src_a & src_b;
            C_OR:    alu_val = src_a | src_b;
            C_XOR:   alu_val = src_a ^ src_b;
            C_SLT:   alu_val = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            C_SLTU:  alu_val = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            C_SLL:   alu_val = src_a << shamt;
            C_SRL:   alu_val = src_a >> shamt;
            C_SRA:   alu_val = WIDTH'($signed(src_a) >>> shamt);
            default: alu_val = '0;
        endcase
    end

    // Control FSM with registered handshake flags and the shift-add multiplier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            result     <= '0;
            zero       <= 1'b0;
            ALUcontrol <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            count_reg  <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        ALUcontrol <= dec_ctl;
                        in_ready   <= 1'b0;
                        if (dec_ctl == C_MUL) begin
                            state_reg  <= S_BUSY;
                            busy       <= 1'b1;
                            count_reg  <= CW'(WIDTH);
                            acc_reg    <= '0;
                            mcand_reg  <= src_a;
                            mplier_reg <= src_b;
                        end else begin
                            state_reg <= S_DONE;
                            out_valid <= 1'b1;
                            result    <= alu_val;
                            zero      <= (alu_val == '0);
                        end
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                S_BUSY: begin
                    acc_reg    <= step_sum;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    count_reg  <= count_reg - CW'(1);
                    // Last step: the counter is about to reach zero.
                    if (count_reg == CW'(1)) begin
                        state_reg <= S_DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        result    <= step_sum;
                        zero      <= (step_sum == '0);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_reg <= S_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: three instances (32-bit with MUL, 32-bit without
// MUL, 8-bit with MUL) checked against an arithmetic reference model, plus
// directed vectors with hand-computed results.
module tb_alu_seq_unit;

    localparam int NDUT = 3;
    localparam int W_OF [NDUT] = '{32, 32, 8};
    localparam int M_OF [NDUT] = '{1, 0, 1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid_x  [NDUT];
    logic [6:0]  op_x        [NDUT];
    logic [1:0]  aluop_x     [NDUT];
    logic [2:0]  f3_x        [NDUT];
    logic [6:0]  f7_x        [NDUT];
    logic [31:0] a_x         [NDUT];
    logic [31:0] b_x         [NDUT];
    logic        out_ready_x [NDUT];

    wire         in_ready_x  [NDUT];
    wire         out_valid_x [NDUT];
    wire  [31:0] res_x       [NDUT];
    wire         zero_x      [NDUT];
    wire  [3:0]  ctl_x       [NDUT];
    wire         busy_x      [NDUT];

    generate
        for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
            localparam int W = W_OF[gi];
            wire [W-1:0] r;
            alu_seq_unit #(.WIDTH(W), .ENABLE_MUL(M_OF[gi])) u_dut (
                .clk        (clk),
                .rst        (rst),
                .in_valid   (in_valid_x[gi]),
                .in_ready   (in_ready_x[gi]),
                .op         (op_x[gi]),
                .ALUop      (aluop_x[gi]),
                .funct3     (f3_x[gi]),
                .funct7     (f7_x[gi]),
                .src_a      (a_x[gi][W-1:0]),
                .src_b      (b_x[gi][W-1:0]),
                .out_valid  (out_valid_x[gi]),
                .out_ready  (out_ready_x[gi]),
                .result     (r),
                .zero       (zero_x[gi]),
                .ALUcontrol (ctl_x[gi]),
                .busy       (busy_x[gi])
            );
            assign res_x[gi] = 32'(r);
        end
    endgenerate

    int n_checks = 0;
    int n_fail   = 0;
    logic [35:0] exp_q [NDUT][$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference decode: straight from the opcode class / funct table.
    function automatic logic [3:0] model_ctl(input int mulen, input logic [1:0] aluop,
                                             input logic [6:0] op, input logic [2:0] f3,
                                             input logic [6:0] f7);
        if (aluop == 2'b01) return 4'd1;
        if (aluop != 2'b10) return 4'd0;
        if (mulen != 0 && op[5] && f7 == 7'b0000001 && f3 == 3'b000) return 4'd10;
        case (f3)
            3'd0: return (op[5] && f7[5]) ? 4'd1 : 4'd0;
            3'd1: return 4'd7;
            3'd2: return 4'd5;
            3'd3: return 4'd6;
            3'd4: return 4'd4;
            3'd5: return f7[5] ? 4'd9 : 4'd8;
            3'd6: return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    // Reference arithmetic in 64-bit integers, reduced modulo 2^w at the end.
    function automatic logic [31:0] model_res(input int w, input logic [3:0] c,
                                              input logic [31:0] a, input logic [31:0] b);
        logic [63:0] m  = (64'd1 << w) - 64'd1;
        logic [63:0] ua = {32'd0, a} & m;
        logic [63:0] ub = {32'd0, b} & m;
        longint sa = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
        longint sb = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
        int sh = int'(ub % 64'(w));
        logic [63:0] r;
        case (c)
            4'd0:  r = ua + ub;
            4'd1:  r = ua - ub;
            4'd2:  r = ua & ub;
            4'd3:  r = ua | ub;
            4'd4:  r = ua ^ ub;
            4'd5:  r = (sa < sb) ? 64'd1 : 64'd0;
            4'd6:  r = (ua < ub) ? 64'd1 : 64'd0;
            4'd7:  r = ua << sh;
            4'd8:  r = ua >> sh;
            4'd9:  r = 64'(sa >>> sh);
            4'd10: r = ua * ub;
            default: r = '0;
        endcase
        r = r & m;
        return r[31:0];
    endfunction

    // Compare process: every cycle a DUT shows out_valid, its outputs must
    // match the oldest accepted request's model result.
    always @(negedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            if (rst) begin
                exp_q[k].delete();
            end else begin
                if (busy_x[k]) chk($sformatf("dut%0d_in_ready_while_busy", k), in_ready_x[k], 0);
                if (out_valid_x[k]) begin
                    if (exp_q[k].size() == 0) begin
                        chk($sformatf("dut%0d_unexpected_out_valid", k), out_valid_x[k], 0);
                    end else begin
                        chk($sformatf("dut%0d_result", k), res_x[k], exp_q[k][0][31:0]);
                        chk($sformatf("dut%0d_zero", k), zero_x[k], exp_q[k][0][31:0] == 32'd0);
                        chk($sformatf("dut%0d_ctl", k), ctl_x[k], exp_q[k][0][35:32]);
                        chk($sformatf("dut%0d_in_ready_in_done", k), in_ready_x[k], 0);
                        if (out_ready_x[k]) void'(exp_q[k].pop_front());
                    end
                end
            end
        end
    end

    task automatic start_op(input int k, input logic [1:0] aluop, input logic [6:0] op,
                            input logic [2:0] f3, input logic [6:0] f7,
                            input logic [31:0] a, input logic [31:0] b, input bit ordy);
        bit got = 0;
        logic [3:0] c;
        @(posedge clk); #1;
        in_valid_x[k] = 1'b1; aluop_x[k] = aluop; op_x[k] = op;
        f3_x[k] = f3; f7_x[k] = f7; a_x[k] = a; b_x[k] = b; out_ready_x[k] = ordy;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            if (in_ready_x[k]) got = 1;
        end
        chk($sformatf("dut%0d_accept_timeout", k), got, 1);
        c = model_ctl(M_OF[k], aluop, op, f3, f7);
        if (got) exp_q[k].push_back({c, model_res(W_OF[k], c, a, b)});
        @(posedge clk); #1;
        in_valid_x[k] = 1'b0;
    endtask

    task automatic finish_op(input int k, input int hold, output logic [31:0] r,
                             output logic z, output logic [3:0] c, output int lat, output int bsy);
        bit seen = 0;
        lat = 0; bsy = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (busy_x[k]) bsy++;
            if (out_valid_x[k]) seen = 1;
        end
        chk($sformatf("dut%0d_done_timeout", k), seen, 1);
        r = res_x[k]; z = zero_x[k]; c = ctl_x[k];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_out_valid", out_valid_x[k], 1);
            chk("hold_result", res_x[k], r);
            chk("hold_ctl", ctl_x[k], c);
            chk("hold_in_ready", in_ready_x[k], 0);
        end
        if (!out_ready_x[k]) begin
            @(posedge clk); #1;
            out_ready_x[k] = 1'b1;
        end
        @(posedge clk); #1;
        out_ready_x[k] = 1'b0;
        @(negedge clk);
        chk($sformatf("dut%0d_in_ready_after_done", k), in_ready_x[k], 1);
        chk($sformatf("dut%0d_out_valid_dropped", k), out_valid_x[k], 0);
    endtask

    task automatic run_op(input int k, input logic [1:0] aluop, input logic [6:0] op,
                          input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] a, input logic [31:0] b, input bit ordy,
                          input int hold, output logic [31:0] r, output logic z,
                          output logic [3:0] c, output int lat);
        int bsy;
        logic [3:0] mc = model_ctl(M_OF[k], aluop, op, f3, f7);
        start_op(k, aluop, op, f3, f7, a, b, ordy);
        finish_op(k, hold, r, z, c, lat, bsy);
        chk($sformatf("dut%0d_latency", k), lat, (mc == 4'd10) ? W_OF[k] + 1 : 1);
        chk($sformatf("dut%0d_busy_cycles", k), bsy, (mc == 4'd10) ? W_OF[k] : 0);
        $display("txn dut%0d ctl=%0d a=%h b=%h result=%h zero=%0b latency=%0d",
                 k, c, a, b, r, z, lat);
    endtask

    initial begin
        logic [31:0] r;
        logic z;
        logic [3:0] c;
        int lat;
        logic [1:0] ra;
        logic [6:0] rop, rf7;
        logic [2:0] rf3;
        logic [31:0] rav, rbv;

        for (int k = 0; k < NDUT; k++) begin
            in_valid_x[k] = 0; op_x[k] = 0; aluop_x[k] = 0; f3_x[k] = 0; f7_x[k] = 0;
            a_x[k] = 0; b_x[k] = 0; out_ready_x[k] = 0;
        end

        // Model pinned against hand-computed values.
        chk("model_sub", model_res(32, 4'd1, 32'd5, 32'd7), 32'hFFFFFFFE);
        chk("model_sra", model_res(32, 4'd9, 32'h80000000, 32'd4), 32'hF8000000);
        chk("model_slt", model_res(32, 4'd5, 32'd1, 32'h80000000), 32'd0);
        chk("model_mul8", model_res(8, 4'd10, 32'h45, 32'h10), 32'h50);

        // Reset state.
        @(negedge clk);
        chk("rst_out_valid", out_valid_x[0], 0);
        chk("rst_result", res_x[0], 0);
        chk("rst_zero", zero_x[0], 0);
        chk("rst_ctl", ctl_x[0], 0);
        chk("rst_busy", busy_x[0], 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("in_ready_after_reset", in_ready_x[0], 1);

        // SUB through funct decode.
        run_op(0, 2'b10, 7'h33, 3'b000, 7'h20, 32'd5, 32'd7, 0, 0, r, z, c, lat);
        chk("sub_ctl", c, 4'b0001); chk("sub_res", r, 32'hFFFFFFFE); chk("sub_zero", z, 0);
        chk("sub_latency", lat, 1);

        // Arithmetic vs logical right shift.
        run_op(0, 2'b10, 7'h33, 3'b101, 7'h20, 32'h80000000, 32'd4, 0, 0, r, z, c, lat);
        chk("sra_res", r, 32'hF8000000); chk("sra_ctl", c, 4'd9);
        run_op(0, 2'b10, 7'h33, 3'b101, 7'h00, 32'h80000000, 32'd4, 0, 0, r, z, c, lat);
        chk("srl_res", r, 32'h08000000); chk("srl_ctl", c, 4'd8);

        // Signed vs unsigned compare.
        run_op(0, 2'b10, 7'h33, 3'b010, 7'h00, 32'd1, 32'h80000000, 0, 0, r, z, c, lat);
        chk("slt_res", r, 32'd0); chk("slt_zero", z, 1);
        run_op(0, 2'b10, 7'h33, 3'b011, 7'h00, 32'd1, 32'h80000000, 0, 0, r, z, c, lat);
        chk("sltu_res", r, 32'd1);

        // Iterative MUL, with out_ready held high throughout.
        run_op(0, 2'b10, 7'h33, 3'b000, 7'h01, 32'h12345, 32'h10, 1, 0, r, z, c, lat);
        chk("mul_res", r, 32'h123450); chk("mul_ctl", c, 4'b1010); chk("mul_latency", lat, 33);
        run_op(1, 2'b10, 7'h33, 3'b000, 7'h01, 32'h12345, 32'h10, 0, 0, r, z, c, lat);
        chk("nomul_res", r, 32'h12355); chk("nomul_ctl", c, 4'b0000); chk("nomul_latency", lat, 1);
        run_op(2, 2'b10, 7'h33, 3'b000, 7'h01, 32'h12345, 32'h10, 0, 0, r, z, c, lat);
        chk("mul8_res", r, 32'h50); chk("mul8_latency", lat, 9);

        // Consumer stalls for five cycles in DONE.
        run_op(0, 2'b10, 7'h33, 3'b100, 7'h00, 32'hF0F0F0F0, 32'hFF00FF00, 0, 5, r, z, c, lat);
        chk("xor_res", r, 32'h0FF00FF0);

        // Reset in the middle of a MUL.
        start_op(0, 2'b10, 7'h33, 3'b000, 7'h01, 32'h12345, 32'h10, 0);
        repeat (10) @(negedge clk);
        chk("mul_busy_before_rst", busy_x[0], 1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid_x[0], 0);
        chk("midrst_busy", busy_x[0], 0);
        chk("midrst_result", res_x[0], 0);
        chk("midrst_zero", zero_x[0], 0);
        chk("midrst_ctl", ctl_x[0], 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_in_ready", in_ready_x[0], 1);
        chk("midrst_no_partial", res_x[0], 0);
        run_op(0, 2'b00, 7'h13, 3'b000, 7'h00, 32'd0, 32'd0, 0, 0, r, z, c, lat);
        chk("add0_zero", z, 1); chk("add0_res", r, 0);

        // Random legal decode sweep on every instance.
        for (int k = 0; k < NDUT; k++) begin
            for (int i = 0; i < 25; i++) begin
                ra  = 2'($urandom_range(0, 3));
                rop = 7'($urandom);
                rf3 = 3'($urandom);
                case ($urandom_range(0, 3))
                    0: rf7 = 7'h00;
                    1: rf7 = 7'h20;
                    2: rf7 = 7'h01;
                    default: rf7 = 7'($urandom);
                endcase
                if ($urandom_range(0, 5) == 0) begin
                    ra = 2'b10; rop[5] = 1'b1; rf3 = 3'b000; rf7 = 7'h01;
                end
                rav = $urandom;
                rbv = $urandom;
                case ($urandom_range(0, 5))
                    0: rbv = rav;
                    1: rbv = 32'h80000000;
                    2: rbv = 32'($urandom_range(0, 40));
                    default: ;
                endcase
                run_op(k, ra, rop, rf3, rf7, rav, rbv, 1'($urandom), 0, r, z, c, lat);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
